// File: rtl/muldiv_alu_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_alu_sequencer_pkg: op, ALU-control and state encodings for muldiv
// Rev 1.0
// ----------------------------------------------------------------------------
package muldiv_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/muldiv_negate64.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_negate64: conditional two's-complement (64-bit by default)
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_negate64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/muldiv_alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_alu_sequencer: MULT/MULTU/DIV/DIVU sequencer time-sharing the core ALU
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_alu_sequencer
  import muldiv_alu_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out
);

  localparam int CW = $clog2(ITERS);

  logic [1:0]      r_state;
  op_e             r_op;
  logic [XLEN-1:0] r_rs;
  logic [XLEN-1:0] r_rt;
  logic [XLEN-1:0] r_hi_acc;
  logic [XLEN-1:0] r_lo_q;
  logic [XLEN-1:0] r_opnd;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_div0;
  logic            r_done;
  logic            r_dbz;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic            w_is_div;
  logic            w_signed;
  logic            w_in_fix;
  logic            w_in_iter;
  logic [XLEN-1:0] w_sh;
  logic            w_top;
  logic            w_carry;
  logic            w_nb;
  logic            w_a31;
  logic            w_b31;
  logic            w_o31;

  logic [2*XLEN-1:0] w_nega_in;
  logic [2*XLEN-1:0] w_nega_out;
  logic              w_nega_en;
  logic [XLEN-1:0]   w_negb_in;
  logic [XLEN-1:0]   w_negb_out;
  logic              w_negb_en;

  assign w_is_div  = (r_op == OP_DIVU) || (r_op == OP_DIV);
  assign w_signed  = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_in_fix  = (r_state == ST_FIX);
  assign w_in_iter = (r_state == ST_ITER);

  // Two negators shared between PREP (operand magnitudes) and FIX (result signs)
  always_comb begin
    w_nega_in = {{XLEN{1'b0}}, r_rs};
    w_nega_en = w_signed & r_rs[XLEN-1];
    w_negb_in = r_rt;
    w_negb_en = w_signed & r_rt[XLEN-1];
    if (w_in_fix) begin
      w_nega_in = w_is_div ? {{XLEN{1'b0}}, r_lo_q} : {r_hi_acc, r_lo_q};
      w_nega_en = r_neg_res;
      w_negb_in = r_hi_acc;
      w_negb_en = r_neg_rem;
    end
  end

  muldiv_negate64 #(.WIDTH(2*XLEN)) u_neg_a (
    .din  (w_nega_in),
    .neg  (w_nega_en),
    .dout (w_nega_out)
  );

  muldiv_negate64 #(.WIDTH(XLEN)) u_neg_b (
    .din  (w_negb_in),
    .neg  (w_negb_en),
    .dout (w_negb_out)
  );

  assign w_sh  = {r_hi_acc[XLEN-2:0], r_lo_q[XLEN-1]};
  assign w_top = r_hi_acc[XLEN-1];

  // ALU port is driven only while iterating; otherwise parked at constants
  always_comb begin
    alu_sel  = w_in_iter;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (w_in_iter) begin
      if (w_is_div) begin
        alu_a    = w_sh;
        alu_b    = r_opnd;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a    = r_hi_acc;
        alu_b    = r_lo_q[0] ? r_opnd : '0;
      end
    end
  end

  assign w_a31   = alu_a[XLEN-1];
  assign w_b31   = alu_b[XLEN-1];
  assign w_o31   = alu_out[XLEN-1];
  assign w_carry = (w_a31 & w_b31) | ((w_a31 | w_b31) & ~w_o31);
  assign w_nb    = (w_a31 & ~w_b31) | ((w_a31 | ~w_b31) & ~w_o31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MULTU;
      r_rs      <= '0;
      r_rt      <= '0;
      r_hi_acc  <= '0;
      r_lo_q    <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_op    <= op_e'(op);
              r_rs    <= rs_val;
              r_rt    <= rt_val;
              r_dbz   <= 1'b0;
              r_state <= ST_PREP;
            end
          end
          ST_PREP: begin
            r_neg_res <= w_signed & (r_rs[XLEN-1] ^ r_rt[XLEN-1]);
            r_neg_rem <= w_signed & r_rs[XLEN-1];
            r_hi_acc  <= '0;
            r_cnt     <= '0;
            // Multiply: mq=|rt|, mcand=|rs|. Divide: q=|rs|, divisor=|rt|.
            r_lo_q    <= w_is_div ? w_nega_out[XLEN-1:0] : w_negb_out;
            r_opnd    <= w_is_div ? w_negb_out : w_nega_out[XLEN-1:0];
            r_div0    <= w_is_div && (w_negb_out == '0);
            r_state   <= (w_is_div && (w_negb_out == '0)) ? ST_FIX : ST_ITER;
          end
          ST_ITER: begin
            if (w_is_div) begin
              if (w_top | w_nb) begin
                r_hi_acc <= alu_out;
                r_lo_q   <= {r_lo_q[XLEN-2:0], 1'b1};
              end else begin
                r_hi_acc <= w_sh;
                r_lo_q   <= {r_lo_q[XLEN-2:0], 1'b0};
              end
            end else begin
              {r_hi_acc, r_lo_q} <= {w_carry, alu_out, r_lo_q[XLEN-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(ITERS-1)) begin
              r_state <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (r_div0) begin
              r_hi  <= r_rs;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else if (w_is_div) begin
              r_hi <= w_negb_out;
              r_lo <= w_nega_out[XLEN-1:0];
            end else begin
              r_hi <= w_nega_out[2*XLEN-1:XLEN];
              r_lo <= w_nega_out[XLEN-1:0];
            end
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_alu_sequencer: randomized self-checking bench with arithmetic model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;
  bit          last_dbz = 1'b0;

  muldiv_alu_sequencer #(.XLEN(32), .ITERS(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .alu_sel     (alu_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out)
  );

  // The core's shared ALU
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a | alu_b;
      3'b010:  alu_out = alu_a + alu_b;
      3'b110:  alu_out = alu_a - alu_b;
      3'b111:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = '0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l, output bit z);
    longint unsigned up;
    longint          sa, sb, sp, sq, sr;
    z  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    if (o[1] && b == 32'd0) begin
      z = 1'b1;
      h = a;
      l = 32'hFFFF_FFFF;
    end else begin
      case (o)
        2'b00: begin up = 64'(a) * 64'(b); {h, l} = up; end
        2'b01: begin sp = sa * sb;         {h, l} = sp; end
        2'b10: begin l = a / b; h = a % b; end
        default: begin
          sq = sa / sb;
          sr = sa % sb;
          l  = sq[31:0];
          h  = sr[31:0];
        end
      endcase
    end
  endfunction

  // Issue one op from the current cycle and follow it to done.
  // poke re-asserts start at edges T+5 and T+20, which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] eh, el;
    bit          ez, seen, busy_ok, ctrl_ok;
    int          k, sel_n, extra;
    ref_model(o, a, b, eh, el, ez);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
    check("busy_after_start", busy, 1);
    check("dbz_cleared_by_start", div_by_zero, 0);
    k = 0; sel_n = 0; seen = 0; busy_ok = 1; ctrl_ok = 1;
    while (!seen && k < 100) begin
      if (poke && (k == 4 || k == 19)) start = 1'b1;
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (alu_sel) begin
        sel_n++;
        if (alu_ctrl !== (o[1] ? 3'b110 : 3'b010)) ctrl_ok = 0;
      end else if (alu_ctrl !== 3'b010 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
        ctrl_ok = 0;
      end
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    check("latency", k, ez ? 2 : 34);
    check("busy_until_done", busy_ok, 1);
    check("busy_low_at_done", busy, 0);
    check("alu_sel_cycles", sel_n, ez ? 0 : 32);
    check("alu_port_ctrl", ctrl_ok, 1);
    check("hi", hi, eh);
    check("lo", lo, el);
    check("div_by_zero", div_by_zero, ez);
    last_hi = eh; last_lo = el; last_dbz = ez;
    if (poke) begin
      extra = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done || busy) extra++;
      end
      check("ignored_start_no_extra", extra, 0);
    end
  endtask

  task automatic flush_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int ev;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy", busy, 0);
    ev = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ev++;
    end
    check("flush_no_done", ev, 0);
    check("flush_hi_kept", hi, last_hi);
    check("flush_lo_kept", lo, last_lo);
    check("flush_dbz_kept", div_by_zero, last_dbz);
  endtask

  function automatic logic [31:0] pick_val(input bit allow_zero);
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(1, 20);
      3:       return allow_zero ? 32'd0 : 32'd3;
      4:       return 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_alu_ctrl", alu_ctrl, 3'b010);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    run_op(2'b01, -32'sd7, 32'd6, 0);
    run_op(2'b11, -32'sd7, 32'd2, 0);
    check("div_neg7_2_lo_const", lo, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'h8000_0000, 32'd1, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(2'b11, 32'd5, 32'd0, 0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b10, 32'h1234_5678, 32'd0, 0);
    run_op(2'b01, 32'd9, 32'hFFFF_FFFD, 1);
    flush_op(2'b11, 32'd1000, 32'd3);
    flush_op(2'b00, 32'd7, 32'd8);

    // Asynchronous reset in the middle of ITER
    op = 2'b00; rs_val = 32'd123; rt_val = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_alu_sel", alu_sel, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_ctrl", alu_ctrl, 3'b010);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op(2'($urandom_range(0, 3)), pick_val(1), pick_val(1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
